// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset controller.
//   - opcode / funct field constants (IR[31:26] / IR[5:0])
//   - ALUOp codes driven to the datapath ALU
//   - controller state codes (exported on mc_ctrl.state)
//   - instruction class and the strobe bundle used inside mc_ctrl
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (see mc_ctrl.sv).
package mc_ctrl_pkg;

   // opcodes
   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_SLLV = 4'd11,
      ALU_SRLV = 4'd12, ALU_SRAV = 4'd13, ALU_LUI  = 4'd14
   } alu_op_e;

   // Codes 5/6 are never entered on purpose; 7 is TRAP when enabled.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CL_RTYPE, CL_JR, CL_IMM, CL_LDST, CL_BRANCH, CL_JUMP, CL_JAL, CL_ILLEGAL
   } instr_class_e;

   // Every datapath strobe; mc_ctrl clears this to zero before decoding.
   typedef struct packed {
      alu_op_e    alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_to_reg;
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       iord;
      logic       sign_ext;
      logic       save_pc;
      logic       jr;
      logic       save_old_pc;
   } ctrl_t;

   // funct_ok / imm_ok come from mc_alu_dec so legality lives in one table.
   function automatic instr_class_e classify(input logic [5:0] opcode,
                                             input logic [5:0] funct,
                                             input logic       funct_ok,
                                             input logic       imm_ok);
      instr_class_e cls;
      cls = CL_ILLEGAL;
      if (opcode == OP_R) begin
         if (funct == FN_JR)  cls = CL_JR;
         else if (funct_ok)   cls = CL_RTYPE;
      end else if (imm_ok) begin
         cls = CL_IMM;
      end else begin
         case (opcode)
            OP_LW, OP_SW:   cls = CL_LDST;
            OP_BEQ, OP_BNE: cls = CL_BRANCH;
            OP_J:           cls = CL_JUMP;
            OP_JAL:         cls = CL_JAL;
            default:        cls = CL_ILLEGAL;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: opcode/funct -> ALUOp decoder.
// Ports:
//   opcode   in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   alu_op   out 4  ALU operation for R-type (from funct) or immediate ALU
//                   (from opcode); ADD for everything else
//   funct_ok out 1  R-type funct is a known ALU op (JR is not counted)
//   imm_ok   out 1  opcode is an immediate ALU instruction
module mc_alu_dec
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_op_e    alu_op,
   output logic       funct_ok,
   output logic       imm_ok
);

   always_comb begin
      alu_op   = ALU_ADD;
      funct_ok = 1'b0;
      imm_ok   = 1'b0;
      if (opcode == OP_R) begin
         funct_ok = 1'b1;
         case (funct)
            FN_SLL:           alu_op = ALU_SLL;
            FN_SRL:           alu_op = ALU_SRL;
            FN_SRA:           alu_op = ALU_SRA;
            FN_SLLV:          alu_op = ALU_SLLV;
            FN_SRLV:          alu_op = ALU_SRLV;
            FN_SRAV:          alu_op = ALU_SRAV;
            FN_ADD, FN_ADDU:  alu_op = ALU_ADD;
            FN_SUB, FN_SUBU:  alu_op = ALU_SUB;
            FN_AND:           alu_op = ALU_AND;
            FN_OR:            alu_op = ALU_OR;
            FN_XOR:           alu_op = ALU_XOR;
            FN_NOR:           alu_op = ALU_NOR;
            FN_SLT:           alu_op = ALU_SLT;
            FN_SLTU:          alu_op = ALU_SLTU;
            default:          funct_ok = 1'b0;
         endcase
      end else begin
         imm_ok = 1'b1;
         case (opcode)
            OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
            OP_SLTI:           alu_op = ALU_SLT;
            OP_SLTIU:          alu_op = ALU_SLTU;
            OP_ANDI:           alu_op = ALU_AND;
            OP_ORI:            alu_op = ALU_OR;
            OP_XORI:           alu_op = ALU_XOR;
            OP_LUI:            alu_op = ALU_LUI;
            default:           imm_ok = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and drives the datapath
// strobes as a pure combinational decode of (state, opcode, funct). Only the
// state register is sequential.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   opcode, funct       IR[31:26], IR[5:0]
//   ALUOp .. SaveOldPC  datapath strobes (see port list)
//   state               current state, for debug
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to send unknown instructions
// to TRAP (state 7), which holds with all strobes low until rst. Without it,
// unknown instructions are NOPs and state 7 falls back to FETCH.
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] ALUOp,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       MemtoReg,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       SignExtend,
   output logic       SavePC,
   output logic       JR,
   output logic       SaveOldPC,
   output logic [2:0] state
);

   state_e       cur, nxt;
   ctrl_t        ctl;
   alu_op_e      dec_op;
   logic         funct_ok, imm_ok;
   instr_class_e cls;

   mc_alu_dec u_alu_dec (
      .opcode   (opcode),
      .funct    (funct),
      .alu_op   (dec_op),
      .funct_ok (funct_ok),
      .imm_ok   (imm_ok)
   );

   assign cls = classify(opcode, funct, funct_ok, imm_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur <= ST_FETCH;
      else     cur <= nxt;
   end

   always_comb begin
      ctl = '0;
      nxt = ST_FETCH;
      case (cur)
         ST_FETCH: begin
            ctl.mem_read  = 1'b1;
            ctl.ir_write  = 1'b1;
            ctl.alu_src_b = 2'b01;
            ctl.alu_op    = ALU_ADD;
            ctl.pc_write  = 1'b1;
            nxt           = ST_DECODE;
         end
         ST_DECODE: begin
            // PC + (imm << 2): branch target parked in ALUOut
            ctl.alu_src_b   = 2'b11;
            ctl.alu_op      = ALU_ADD;
            ctl.sign_ext    = 1'b1;
            ctl.save_old_pc = (opcode == OP_JAL);
            nxt             = ST_EXEC;
         end
         ST_EXEC: begin
            case (cls)
               CL_RTYPE: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_src_b = 2'b00;
                  ctl.alu_op    = dec_op;
                  nxt           = ST_WB;
               end
               CL_JR: begin
                  ctl.jr       = 1'b1;
                  ctl.pc_write = 1'b1;
               end
               CL_IMM: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_src_b = 2'b10;
                  ctl.alu_op    = dec_op;
                  // logical immediates are zero-extended
                  ctl.sign_ext  = !(opcode inside {OP_ANDI, OP_ORI, OP_XORI});
                  nxt           = ST_WB;
               end
               CL_LDST: begin
                  ctl.alu_src_a = 1'b1;
                  ctl.alu_src_b = 2'b10;
                  ctl.sign_ext  = 1'b1;
                  ctl.alu_op    = ALU_ADD;
                  nxt           = ST_MEM;
               end
               CL_BRANCH: begin
                  // ALU zero/non-zero qualifies PCWriteCond in the datapath
                  ctl.alu_src_a     = 1'b1;
                  ctl.alu_src_b     = 2'b00;
                  ctl.alu_op        = ALU_SUB;
                  ctl.pc_write_cond = 1'b1;
                  ctl.pc_source     = 2'b01;
               end
               CL_JUMP: begin
                  ctl.pc_write  = 1'b1;
                  ctl.pc_source = 2'b10;
               end
               CL_JAL: begin
                  ctl.pc_write  = 1'b1;
                  ctl.pc_source = 2'b10;
                  ctl.save_pc   = 1'b1;
                  ctl.reg_write = 1'b1;
               end
               default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                  nxt = ST_TRAP;
`else
                  nxt = ST_FETCH;
`endif
               end
            endcase
         end
         ST_MEM: begin
            // keep recomputing the address so ALUOut stays valid
            ctl.iord      = 1'b1;
            ctl.alu_src_a = 1'b1;
            ctl.alu_src_b = 2'b10;
            ctl.sign_ext  = 1'b1;
            ctl.alu_op    = ALU_ADD;
            if (opcode == OP_LW) begin
               ctl.mem_read = 1'b1;
               nxt          = ST_WB;
            end else if (opcode == OP_SW) begin
               ctl.mem_write = 1'b1;
            end
         end
         ST_WB: begin
            if (opcode == OP_LW) begin
               ctl.reg_write  = 1'b1;
               ctl.mem_to_reg = 1'b1;
            end else if (cls == CL_RTYPE) begin
               ctl.reg_write = 1'b1;
               ctl.reg_dst   = 1'b1;
            end else if (cls == CL_IMM) begin
               ctl.reg_write = 1'b1;
            end
         end
`ifdef CTRL_ILLEGAL_TRAP_EN
         ST_TRAP: nxt = ST_TRAP;
`endif
         default: nxt = ST_FETCH;
      endcase
   end

   assign ALUOp       = ctl.alu_op;
   assign MemRead     = ctl.mem_read;
   assign MemWrite    = ctl.mem_write;
   assign IRWrite     = ctl.ir_write;
   assign RegDst      = ctl.reg_dst;
   assign RegWrite    = ctl.reg_write;
   assign ALUSrcA     = ctl.alu_src_a;
   assign ALUSrcB     = ctl.alu_src_b;
   assign MemtoReg    = ctl.mem_to_reg;
   assign PCWrite     = ctl.pc_write;
   assign PCWriteCond = ctl.pc_write_cond;
   assign PCSource    = ctl.pc_source;
   assign IorD        = ctl.iord;
   assign SignExtend  = ctl.sign_ext;
   assign SavePC      = ctl.save_pc;
   assign JR          = ctl.jr;
   assign SaveOldPC   = ctl.save_old_pc;
   assign state       = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Instructions are run one at a
// time; a table-driven reference model gives the expected state path and the
// expected strobe vector in every state.
module tb_mc_ctrl;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       mem_read, mem_write, ir_write, reg_dst, reg_write, alu_src_a;
      logic [1:0] alu_src_b;
      logic       mem_to_reg, pc_write, pc_write_cond;
      logic [1:0] pc_source;
      logic       iord, sign_ext, save_pc, jr, save_old_pc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   logic [3:0] ALUOp;
   logic       MemRead, MemWrite, IRWrite, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       MemtoReg, PCWrite, PCWriteCond;
   logic [1:0] PCSource;
   logic       IorD, SignExtend, SavePC, JR, SaveOldPC;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   // -1 marks "not an ALU instruction"
   int fn_alu  [64];
   int imm_alu [64];

   mc_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .MemtoReg(MemtoReg), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .IorD(IorD), .SignExtend(SignExtend), .SavePC(SavePC),
      .JR(JR), .SaveOldPC(SaveOldPC), .state(state)
   );

   always #5 clk = ~clk;

   exp_t got;
   assign got = '{ALUOp, MemRead, MemWrite, IRWrite, RegDst, RegWrite, ALUSrcA,
                  ALUSrcB, MemtoReg, PCWrite, PCWriteCond, PCSource, IorD,
                  SignExtend, SavePC, JR, SaveOldPC};

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   function automatic bit is_r_alu(input logic [5:0] op, input logic [5:0] fn);
      return op == 6'h00 && fn != 6'h08 && fn_alu[fn] >= 0;
   endfunction

   function automatic bit is_imm(input logic [5:0] op);
      return imm_alu[op] >= 0;
   endfunction

   function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'h00) return fn == 6'h08 || fn_alu[fn] >= 0;
      return is_imm(op) || op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h23, 6'h2B};
   endfunction

   // What the datapath must see in state st while running (op, fn).
   function automatic exp_t exp_out(input int st, input logic [5:0] op,
                                    input logic [5:0] fn);
      exp_t e = '0;
      case (st)
         0: begin
            e.mem_read = 1; e.ir_write = 1; e.alu_src_b = 2'b01; e.pc_write = 1;
         end
         1: begin
            e.alu_src_b = 2'b11; e.sign_ext = 1; e.save_old_pc = (op == 6'h03);
         end
         2: begin
            if (is_r_alu(op, fn)) begin
               e.alu_src_a = 1; e.alu_op = 4'(fn_alu[fn]);
            end else if (op == 6'h00 && fn == 6'h08) begin
               e.jr = 1; e.pc_write = 1;
            end else if (is_imm(op)) begin
               e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 4'(imm_alu[op]);
               e.sign_ext = !(op inside {6'h0C, 6'h0D, 6'h0E});
            end else if (op == 6'h23 || op == 6'h2B) begin
               e.alu_src_a = 1; e.alu_src_b = 2'b10; e.sign_ext = 1;
            end else if (op == 6'h04 || op == 6'h05) begin
               e.alu_src_a = 1; e.alu_op = 4'd1; e.pc_write_cond = 1; e.pc_source = 2'b01;
            end else if (op == 6'h02) begin
               e.pc_write = 1; e.pc_source = 2'b10;
            end else if (op == 6'h03) begin
               e.pc_write = 1; e.pc_source = 2'b10; e.save_pc = 1; e.reg_write = 1;
            end
         end
         3: begin
            e.iord = 1; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.sign_ext = 1;
            e.mem_read = (op == 6'h23); e.mem_write = (op == 6'h2B);
         end
         4: begin
            if (op == 6'h23) begin
               e.reg_write = 1; e.mem_to_reg = 1;
            end else if (is_r_alu(op, fn)) begin
               e.reg_write = 1; e.reg_dst = 1;
            end else if (is_imm(op)) begin
               e.reg_write = 1;
            end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs one instruction starting at a negedge in FETCH; checks the state and
   // every strobe in each cycle, then the state it ends in. Returns cycles.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input string tag, output int cycles);
      int path[$];
      int tail;
      path = '{0, 1, 2};
      if (is_r_alu(op, fn) || is_imm(op)) path.push_back(4);
      else if (op == 6'h23) begin path.push_back(3); path.push_back(4); end
      else if (op == 6'h2B) path.push_back(3);
      tail = (TRAP && !is_legal(op, fn)) ? 7 : 0;
      opcode = op;
      funct  = fn;
      cycles = 0;
      foreach (path[i]) begin
         n_checks++;
         if (state !== 3'(path[i])) begin
            n_fail++;
            $display("FAIL %s state step %0d: got %0d need %0d", tag, i, state, path[i]);
         end
         n_checks++;
         if (got !== exp_out(path[i], op, fn)) begin
            n_fail++;
            $display("FAIL %s strobes st=%0d: got %h need %h", tag, path[i], got,
                     exp_out(path[i], op, fn));
         end
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      n_checks++;
      if (state !== 3'(tail)) begin
         n_fail++;
         $display("FAIL %s end state: got %0d need %0d", tag, state, tail);
      end
      if (tail == 7) begin
         repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (state !== 3'd7 || got !== '0) begin
               n_fail++;
               $display("FAIL %s trap hold: got st=%0d strobes=%h need 7/0", tag, state, got);
            end
         end
         do_reset();
      end
   endtask

   task automatic test_reset();
      int cyc;
      rst = 1'b1;
      opcode = 6'h23;
      funct  = 6'h00;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset state: got %0d need 0", state);
      end
      n_checks++;
      if (got !== exp_out(0, opcode, funct)) begin
         n_fail++;
         $display("FAIL reset strobes: got %h need %h", got, exp_out(0, opcode, funct));
      end
      rst = 1'b0;
      run_instr(6'h23, 6'h00, "lw", cyc);
      n_checks++;
      if (cyc != 5) begin
         n_fail++;
         $display("FAIL lw cpi: got %0d need 5", cyc);
      end
   endtask

   task automatic test_rtype();
      int cyc;
      run_instr(6'h00, 6'h22, "sub", cyc);
      n_checks++;
      if (cyc != 4) begin
         n_fail++;
         $display("FAIL sub cpi: got %0d need 4", cyc);
      end
      run_instr(6'h00, 6'h00, "sll_nop", cyc);
      run_instr(6'h00, 6'h27, "nor", cyc);
   endtask

   task automatic test_imm();
      int cyc;
      run_instr(6'h0D, 6'h15, "ori", cyc);
      run_instr(6'h08, 6'h3F, "addi", cyc);
      run_instr(6'h0F, 6'h00, "lui", cyc);
      run_instr(6'h2B, 6'h00, "sw", cyc);
      n_checks++;
      if (cyc != 4) begin
         n_fail++;
         $display("FAIL sw cpi: got %0d need 4", cyc);
      end
   endtask

   task automatic test_branch_jump();
      int cyc;
      run_instr(6'h04, 6'h00, "beq", cyc);
      n_checks++;
      if (cyc != 3) begin
         n_fail++;
         $display("FAIL beq cpi: got %0d need 3", cyc);
      end
      run_instr(6'h05, 6'h11, "bne", cyc);
      run_instr(6'h02, 6'h00, "j", cyc);
      run_instr(6'h03, 6'h00, "jal", cyc);
      run_instr(6'h00, 6'h08, "jr", cyc);
      n_checks++;
      if (cyc != 3) begin
         n_fail++;
         $display("FAIL jr cpi: got %0d need 3", cyc);
      end
   endtask

   task automatic test_reset_mid();
      opcode = 6'h2B;
      funct  = 6'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL rst_mid precondition: got %0d need 3", state);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (state !== 3'd0 || MemWrite !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid abort: got st=%0d MemWrite=%b need 0/0", state, MemWrite);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_illegal();
      int cyc;
      run_instr(6'h3F, 6'h00, "bad_op", cyc);
      run_instr(6'h00, 6'h01, "bad_fn", cyc);
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                             6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
      logic [5:0] fns[17] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20,
                             6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B};
      logic [5:0] op, fn;
      int cyc;
      for (int k = 0; k < 80; k++) begin
         op = ops[$urandom_range(14, 0)];
         fn = fns[$urandom_range(16, 0)];
         if (!TRAP && $urandom_range(9, 0) == 0) begin
            op = 6'($urandom);
            fn = 6'($urandom);
         end
         run_instr(op, fn, "rand", cyc);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         fn_alu[i]  = -1;
         imm_alu[i] = -1;
      end
      fn_alu[6'h00] = 8;  fn_alu[6'h02] = 9;  fn_alu[6'h03] = 10; fn_alu[6'h04] = 11;
      fn_alu[6'h06] = 12; fn_alu[6'h07] = 13; fn_alu[6'h20] = 0;  fn_alu[6'h21] = 0;
      fn_alu[6'h22] = 1;  fn_alu[6'h23] = 1;  fn_alu[6'h24] = 2;  fn_alu[6'h25] = 3;
      fn_alu[6'h26] = 4;  fn_alu[6'h27] = 5;  fn_alu[6'h2A] = 6;  fn_alu[6'h2B] = 7;
      imm_alu[6'h08] = 0; imm_alu[6'h09] = 0; imm_alu[6'h0A] = 6; imm_alu[6'h0B] = 7;
      imm_alu[6'h0C] = 2; imm_alu[6'h0D] = 3; imm_alu[6'h0E] = 4; imm_alu[6'h0F] = 14;

      test_reset();
      test_rtype();
      test_imm();
      test_branch_jump();
      test_reset_mid();
      test_illegal();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
